// File: rtl/imm_gen_pipe_if.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe_if
// Purpose : Bundles the upstream (decode-side) and downstream (ID/EX-side)
//           valid/ready handshakes of the immediate-generation stage.
// Signals : in_valid/in_ready/in_instr/in_imm_src/in_tag   - upstream side
//           out_valid/out_ready/out_imm/out_imm_src/out_tag/out_err
//                                                           - downstream side
// Modports: slave  - the immediate stage itself
//           master - whatever surrounds the stage (decode + ID/EX register)
// ----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_imm_src;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [2:0]       out_imm_src;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport slave (
        input  in_valid, in_instr, in_imm_src, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_imm_src, out_tag, out_err
    );

    modport master (
        output in_valid, in_instr, in_imm_src, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_imm_src, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// imm_gen_pipe
// Purpose : Registered RISC-V immediate generator. Decodes I/S/B/J/U, shift
//           amount and CSR zimm immediates to XLEN bits when an instruction
//           is accepted, and holds the results in a 2-entry elastic buffer
//           with a pass-through tag.
// Ports   : clk   - clock, rising edge
//           rst   - synchronous active-high reset (clears storage too)
//           flush - drops all buffered entries and any same-cycle transfer
//           bus   - imm_gen_pipe_if.slave, upstream and downstream handshakes
// ----------------------------------------------------------------------------
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);

    localparam logic [2:0] SRC_I     = 3'b000;
    localparam logic [2:0] SRC_S     = 3'b001;
    localparam logic [2:0] SRC_B     = 3'b010;
    localparam logic [2:0] SRC_J     = 3'b011;
    localparam logic [2:0] SRC_U     = 3'b100;
    localparam logic [2:0] SRC_SHAMT = 3'b101;
    localparam logic [2:0] SRC_ZIMM  = 3'b110;

    logic [XLEN-1:0]  immQ [2];
    logic [2:0]       srcQ [2];
    logic [TAG_W-1:0] tagQ [2];
    logic             errQ [2];

    logic       wrPtrQ, wrPtrD;
    logic       rdPtrQ, rdPtrD;
    logic [1:0] countQ, countD;

    logic            inReady;
    logic            outValid;
    logic            doWrite;
    logic            doRead;
    logic [XLEN-1:0] decImm;
    logic            decErr;
    logic [31:0]     ins;
    logic            unusedOpcode;

    assign ins          = bus.in_instr;
    assign unusedOpcode = ^ins[6:0];

    assign inReady  = (countQ != 2'd2);
    assign outValid = (countQ != 2'd0);
    assign doWrite  = bus.in_valid && inReady && !flush;
    assign doRead   = outValid && bus.out_ready && !flush;

    // Immediate decode of the incoming word. Size casts of signed operands
    // sign-extend, casts of unsigned operands zero-extend.
    always_comb begin
        decImm = '0;
        decErr = 1'b0;
        case (bus.in_imm_src)
            SRC_I: decImm = XLEN'($signed(ins[31:20]));
            SRC_S: decImm = XLEN'($signed({ins[31:25], ins[11:7]}));
            SRC_B: decImm = XLEN'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
            SRC_J: decImm = XLEN'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
            SRC_U: decImm = XLEN'($signed({ins[31:12], 12'b0}));
            SRC_SHAMT: begin
                if (XLEN == 32) begin
                    // RV32 shifts only have 5 shamt bits; bit 25 set is illegal.
                    decImm = XLEN'(ins[24:20]);
                    decErr = ins[25];
                end else begin
                    decImm = XLEN'(ins[25:20]);
                end
            end
            SRC_ZIMM: decImm = XLEN'(ins[19:15]);
            default: begin
                decImm = '0;
                decErr = 1'b1;
            end
        endcase
    end

    // Pointer/count update. flush wins over both handshakes; a simultaneous
    // read and write leaves the count unchanged.
    always_comb begin
        wrPtrD = wrPtrQ;
        rdPtrD = rdPtrQ;
        countD = countQ;
        if (flush) begin
            wrPtrD = 1'b0;
            rdPtrD = 1'b0;
            countD = 2'd0;
        end else begin
            if (doWrite) wrPtrD = ~wrPtrQ;
            if (doRead)  rdPtrD = ~rdPtrQ;
            case ({doWrite, doRead})
                2'b10:   countD = countQ + 2'd1;
                2'b01:   countD = countQ - 2'd1;
                default: countD = countQ;
            endcase
        end
    end

    // State and storage registers; reset also wipes the entry contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrQ <= 1'b0;
            rdPtrQ <= 1'b0;
            countQ <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                immQ[i] <= '0;
                srcQ[i] <= '0;
                tagQ[i] <= '0;
                errQ[i] <= 1'b0;
            end
        end else begin
            wrPtrQ <= wrPtrD;
            rdPtrQ <= rdPtrD;
            countQ <= countD;
            if (doWrite) begin
                immQ[wrPtrQ] <= decImm;
                srcQ[wrPtrQ] <= bus.in_imm_src;
                tagQ[wrPtrQ] <= bus.in_tag;
                errQ[wrPtrQ] <= decErr;
            end
        end
    end

    // Outputs come straight from the head entry, forced to zero when empty.
    assign bus.in_ready    = inReady;
    assign bus.out_valid   = outValid;
    assign bus.out_imm     = outValid ? immQ[rdPtrQ] : '0;
    assign bus.out_imm_src = outValid ? srcQ[rdPtrQ] : '0;
    assign bus.out_tag     = outValid ? tagQ[rdPtrQ] : '0;
    assign bus.out_err     = outValid ? errQ[rdPtrQ] : 1'b0;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// ----------------------------------------------------------------------------
// tb_imm_gen_pipe
// Purpose : Drives an XLEN=32 and an XLEN=64 instance of imm_gen_pipe with
//           identical stimulus and compares both against a queue-based
//           reference model that decodes immediates arithmetically.
// ----------------------------------------------------------------------------
module tb_imm_gen_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  src;
        logic [7:0]  tag;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    logic flush;

    int testCount = 0;
    int failCount = 0;

    rec_t modelQ[$];

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(8)) bus32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(8)) bus64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus32.slave)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus64.slave)
    );

    always #5 clk = ~clk;

    // Treat v as a bits-wide two's complement number.
    function automatic longint sx(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        if (v >= half) return v - (half << 1);
        return v;
    endfunction

    // Reference immediate built with shifts/masks and signed arithmetic.
    function automatic longint refImm(input logic [31:0] instr, input logic [2:0] src,
                                      input bit is64, output bit err);
        longint u;
        longint v;
        u   = longint'({32'b0, instr});
        err = 1'b0;
        case (src)
            3'd0: v = sx((u >> 20) & 'hFFF, 12);
            3'd1: v = sx((((u >> 25) & 'h7F) << 5) | ((u >> 7) & 'h1F), 12);
            3'd2: v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                         (((u >> 25) & 'h3F) << 5) | (((u >> 8) & 'hF) << 1), 13);
            3'd3: v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 'hFF) << 12) |
                         (((u >> 20) & 1) << 11) | (((u >> 21) & 'h3FF) << 1), 21);
            3'd4: v = sx(u & 'hFFFFF000, 32);
            3'd5: begin
                if (is64) v = (u >> 20) & 'h3F;
                else begin
                    v   = (u >> 20) & 'h1F;
                    err = ((u >> 25) & 1) != 0;
                end
            end
            3'd6: v = (u >> 15) & 'h1F;
            default: begin
                v   = 0;
                err = 1'b1;
            end
        endcase
        return v;
    endfunction

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare both instances with the model state after an edge.
    task automatic checkOutput();
        bit       valid;
        bit       e32, e64;
        longint   v32, v64;
        logic [2:0] src;
        logic [7:0] tag;
        valid = modelQ.size() != 0;
        v32 = 0; v64 = 0; e32 = 0; e64 = 0; src = '0; tag = '0;
        if (valid) begin
            v32 = refImm(modelQ[0].instr, modelQ[0].src, 1'b0, e32);
            v64 = refImm(modelQ[0].instr, modelQ[0].src, 1'b1, e64);
            src = modelQ[0].src;
            tag = modelQ[0].tag;
        end
        checkVal("in_ready32",  64'(bus32.in_ready),    64'(modelQ.size() != 2));
        checkVal("out_valid32", 64'(bus32.out_valid),   64'(valid));
        checkVal("out_imm32",   64'(bus32.out_imm),     64'(v32[31:0]));
        checkVal("out_src32",   64'(bus32.out_imm_src), 64'(src));
        checkVal("out_tag32",   64'(bus32.out_tag),     64'(tag));
        checkVal("out_err32",   64'(bus32.out_err),     64'(e32));
        checkVal("in_ready64",  64'(bus64.in_ready),    64'(modelQ.size() != 2));
        checkVal("out_valid64", 64'(bus64.out_valid),   64'(valid));
        checkVal("out_imm64",   bus64.out_imm,          64'(v64));
        checkVal("out_src64",   64'(bus64.out_imm_src), 64'(src));
        checkVal("out_tag64",   64'(bus64.out_tag),     64'(tag));
        checkVal("out_err64",   64'(bus64.out_err),     64'(e64));
    endtask

    // One clock of stimulus: drive, advance the model at the edge, check.
    task automatic applyStimulus(input bit valid, input logic [31:0] instr,
                                 input logic [2:0] src, input logic [7:0] tag,
                                 input bit outReady, input bit flushV, input bit rstV,
                                 output bit accepted);
        bit rd;
        rec_t r;
        bus32.in_valid = valid;  bus64.in_valid = valid;
        bus32.in_instr = instr;  bus64.in_instr = instr;
        bus32.in_imm_src = src;  bus64.in_imm_src = src;
        bus32.in_tag = tag;      bus64.in_tag = tag;
        bus32.out_ready = outReady; bus64.out_ready = outReady;
        flush = flushV;
        rst   = rstV;
        accepted = valid && modelQ.size() < 2 && !flushV && !rstV;
        rd       = modelQ.size() > 0 && outReady && !flushV && !rstV;
        @(posedge clk);
        if (flushV || rstV) modelQ.delete();
        else begin
            if (rd) void'(modelQ.pop_front());
            if (accepted) begin
                r.instr = instr; r.src = src; r.tag = tag;
                modelQ.push_back(r);
            end
        end
        #1;
        checkOutput();
    endtask

    initial begin
        bit acc;
        bit pendValid;
        logic [31:0] pendInstr;
        logic [2:0]  pendSrc;
        logic [7:0]  pendTag;

        bus32.in_valid = 0; bus64.in_valid = 0;
        bus32.in_instr = 0; bus64.in_instr = 0;
        bus32.in_imm_src = 0; bus64.in_imm_src = 0;
        bus32.in_tag = 0; bus64.in_tag = 0;
        bus32.out_ready = 0; bus64.out_ready = 0;
        flush = 0;
        rst   = 1;
        #1;

        // Reset state
        applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, acc);
        checkVal("rst_in_ready", 64'(bus32.in_ready), 64'd1);
        checkVal("rst_out_valid", 64'(bus64.out_valid), 64'd0);

        // Single I-type push
        applyStimulus(1, 32'hFFF00093, 3'd0, 8'h11, 1, 0, 0, acc);
        checkVal("t1_imm32", 64'(bus32.out_imm), 64'hFFFFFFFF);
        checkVal("t1_tag", 64'(bus32.out_tag), 64'h11);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);

        // Back-to-back B, U, J
        applyStimulus(1, 32'hFE000EE3, 3'd2, 8'h21, 1, 0, 0, acc);
        checkVal("t2_b", 64'(bus32.out_imm), 64'hFFFFFFFC);
        applyStimulus(1, 32'h123450B7, 3'd4, 8'h22, 1, 0, 0, acc);
        checkVal("t2_u", 64'(bus32.out_imm), 64'h12345000);
        applyStimulus(1, 32'h0010006F, 3'd3, 8'h23, 1, 0, 0, acc);
        checkVal("t2_j", 64'(bus32.out_imm), 64'h00000800);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);

        // Backpressure: third entry held until the first pop
        applyStimulus(1, 32'h00500093, 3'd0, 8'h31, 0, 0, 0, acc);
        applyStimulus(1, 32'h00A12423, 3'd1, 8'h32, 0, 0, 0, acc);
        checkVal("t3_full", 64'(bus32.in_ready), 64'd0);
        applyStimulus(1, 32'h340020F3, 3'd6, 8'h33, 0, 0, 0, acc);
        checkVal("t3_held", 64'(acc), 64'd0);
        applyStimulus(1, 32'h340020F3, 3'd6, 8'h33, 1, 0, 0, acc);
        applyStimulus(1, 32'h340020F3, 3'd6, 8'h33, 1, 0, 0, acc);
        checkVal("t3_tag3", 64'(bus32.out_tag), 64'h33);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);

        // Shift amounts and illegal select
        applyStimulus(1, 32'h02009093, 3'd5, 8'h41, 1, 0, 0, acc);
        checkVal("t4_sh_err32", 64'(bus32.out_err), 64'd1);
        checkVal("t4_sh_imm64", bus64.out_imm, 64'h20);
        applyStimulus(1, 32'h02109093, 3'd5, 8'h42, 1, 0, 0, acc);
        checkVal("t4_sh_imm32", 64'(bus32.out_imm), 64'h1);
        checkVal("t4_sh_imm64b", bus64.out_imm, 64'h21);
        applyStimulus(1, 32'hFFFFFFFF, 3'd7, 8'h43, 1, 0, 0, acc);
        checkVal("t4_ill_err", 64'(bus64.out_err), 64'd1);

        // 64-bit sign extension
        applyStimulus(1, 32'hFFF00093, 3'd0, 8'h51, 1, 0, 0, acc);
        checkVal("t5_i64", bus64.out_imm, 64'hFFFFFFFFFFFFFFFF);
        applyStimulus(1, 32'h800000B7, 3'd4, 8'h52, 1, 0, 0, acc);
        checkVal("t5_u64", bus64.out_imm, 64'hFFFFFFFF80000000);
        applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);

        // Flush and reset with two entries buffered and a pending input
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 32'h00100093, 3'd0, 8'h61, 0, 0, 0, acc);
            applyStimulus(1, 32'h00200093, 3'd0, 8'h62, 0, 0, 0, acc);
            applyStimulus(1, 32'h00300093, 3'd0, 8'h63, 1, k == 0, k == 1, acc);
            checkVal("t6_empty", 64'(bus32.out_valid), 64'd0);
            checkVal("t6_ready", 64'(bus64.in_ready), 64'd1);
            for (int c = 0; c < 3; c++) applyStimulus(0, 0, 0, 0, 1, 0, 0, acc);
        end

        // Randomized traffic with occasional flush
        pendValid = 0; pendInstr = 0; pendSrc = 0; pendTag = 0;
        acc = 0;
        for (int n = 0; n < 400; n++) begin
            if (!pendValid || acc) begin
                pendValid = $urandom_range(0, 3) != 0;
                pendInstr = $urandom;
                pendSrc   = 3'($urandom_range(0, 7));
                pendTag   = 8'($urandom);
            end
            applyStimulus(pendValid, pendInstr, pendSrc, pendTag,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0, 0, acc);
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
